// File: rtl/compuertas_pkg.sv
// -----------------------------------------------------------------------------
// compuertas_pkg
// Shared definitions for the compuertas_bist self-test block:
//   - FSM state encoding (IDLE=0, DRIVE=1, SETTLE=2, SAMPLE=3, DONE=4, 3 bits)
//   - number of input vectors exercised on the 3-input gate block
//   - default golden truth tables (S1 = A&B, S2 = B|C), indexed by {A,B,C}
//   - helper that sizes the settle down-counter
// No ports (package).
// -----------------------------------------------------------------------------
package compuertas_pkg;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_DRIVE_ENC  = 3'd1;
  localparam logic [2:0] ST_SETTLE_ENC = 3'd2;
  localparam logic [2:0] ST_SAMPLE_ENC = 3'd3;
  localparam logic [2:0] ST_DONE_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_DRIVE  = ST_DRIVE_ENC,
    ST_SETTLE = ST_SETTLE_ENC,
    ST_SAMPLE = ST_SAMPLE_ENC,
    ST_DONE   = ST_DONE_ENC
  } state_t;

  localparam int unsigned NUM_VECTORS = 8;
  localparam logic [2:0]  LAST_IDX    = 3'd7;

  // Golden tables, bit i corresponds to input vector {A,B,C} == i.
  localparam logic [7:0] EXP_S1_DEFAULT = 8'b1100_0000;  // A & B
  localparam logic [7:0] EXP_S2_DEFAULT = 8'b1110_1110;  // B | C

  // Settle counter width: enough to hold SETTLE_CYCLES, never below 1 bit.
  function automatic int unsigned timer_width(input int unsigned settle);
    int unsigned w;
    w = $clog2(settle + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage : compuertas_pkg

// File: rtl/compuertas_bist_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
// Loadable down-counter used to hold the BIST in SETTLE for a fixed number of
// cycles after a new vector is applied.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   load      in   load load_val (takes priority over en)
//   en        in   decrement by one
//   load_val  in   W-bit reload value
//   last      out  counter currently holds 1 (final settle cycle)
// -----------------------------------------------------------------------------
module settle_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] r_count;

  // Counter register: reload on load, otherwise count down while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      r_count <= r_count - W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign last = (r_count == W'(1));

endmodule : settle_timer

// File: rtl/compuertas_bist.sv
// -----------------------------------------------------------------------------
// compuertas_bist
// Built-in self-test for the 3-input / 2-output gate block. Walks all eight
// {A,B,C} vectors, waits SETTLE_CYCLES after each, samples S1/S2 and compares
// against the golden tables. Reports mismatch count, pass/fail and the first
// failing vector.
//
// Optional feature macro: COMPUERTAS_BIST_FAIL_MASK_EN
//   When defined, adds output fail_mask[7:0] with one bit per failing vector.
//
// Ports:
//   clk, rst           clock (rising edge) / async active-high reset
//   start              begin a run (honoured only in IDLE or DONE)
//   s1_in, s2_in       outputs of the gate block under test (synchronous)
//   a_out,b_out,c_out  drive gate block inputs A, B, C
//   busy               high in DRIVE, SETTLE, SAMPLE
//   done               high in DONE until next accepted start or reset
//   pass               valid with done: 1 iff err_count == 0
//   err_count[3:0]     number of mismatching vectors (0..8)
//   first_fail_idx[2:0], first_fail_valid   first mismatching vector
//   fail_mask[7:0]     (macro only) per-vector mismatch flags
// -----------------------------------------------------------------------------
module compuertas_bist
  import compuertas_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXP_S1        = EXP_S1_DEFAULT,
  parameter logic [7:0]  EXP_S2        = EXP_S2_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       s1_in,
  input  logic       s2_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_idx,
  output logic       first_fail_valid
`ifdef COMPUERTAS_BIST_FAIL_MASK_EN
  ,
  output logic [7:0] fail_mask
`endif
);

  localparam int unsigned TW          = timer_width(SETTLE_CYCLES);
  localparam bit          SKIP_SETTLE = (SETTLE_CYCLES == 0);

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_idx;
  logic [2:0]  r_abc;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [3:0]  r_err_count;
  logic [2:0]  r_first_fail_idx;
  logic        r_first_fail_valid;

  logic        w_start_acc;
  logic        w_sample_exit;
  logic        w_timer_load;
  logic        w_timer_en;
  logic        w_timer_last;
  logic        w_mismatch;
  logic [3:0]  w_err_next;
  logic        w_busy_next;

  settle_timer #(
    .W (TW)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_timer_load),
    .en       (w_timer_en),
    .load_val (TW'(SETTLE_CYCLES)),
    .last     (w_timer_last)
  );

  assign w_mismatch = (s1_in != EXP_S1[r_idx]) | (s2_in != EXP_S2[r_idx]);
  // Error count including the vector being sampled now; used for pass on the last vector.
  assign w_err_next = r_err_count + {3'b000, w_mismatch};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    w_state_next  = r_state;
    w_start_acc   = 1'b0;
    w_sample_exit = 1'b0;
    w_timer_load  = 1'b0;
    w_timer_en    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_next = ST_DRIVE;
          w_start_acc  = 1'b1;
        end else begin
          w_state_next = r_state;
        end
      end
      ST_DRIVE: begin
        w_timer_load = 1'b1;
        if (SKIP_SETTLE) begin
          w_state_next = ST_SAMPLE;
        end else begin
          w_state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_timer_en = 1'b1;
        if (w_timer_last) begin
          w_state_next = ST_SAMPLE;
        end else begin
          w_state_next = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        w_sample_exit = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_DRIVE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // busy is registered from the next state so it lines up with the state register.
  always_comb begin
    w_busy_next = 1'b0;
    case (w_state_next)
      ST_DRIVE, ST_SETTLE, ST_SAMPLE: w_busy_next = 1'b1;
      default:                        w_busy_next = 1'b0;
    endcase
  end

  // Status register for busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Vector index, DUT drive and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx              <= 3'd0;
      r_abc              <= 3'd0;
      r_done             <= 1'b0;
      r_pass             <= 1'b0;
      r_err_count        <= 4'd0;
      r_first_fail_idx   <= 3'd0;
      r_first_fail_valid <= 1'b0;
    end else if (w_start_acc) begin
      r_idx              <= 3'd0;
      r_abc              <= 3'd0;
      r_done             <= 1'b0;
      r_pass             <= 1'b0;
      r_err_count        <= 4'd0;
      r_first_fail_idx   <= 3'd0;
      r_first_fail_valid <= 1'b0;
    end else if (w_sample_exit) begin
      r_err_count <= w_err_next;
      if (w_mismatch && !r_first_fail_valid) begin
        r_first_fail_idx   <= r_idx;
        r_first_fail_valid <= 1'b1;
      end else begin
        r_first_fail_idx   <= r_first_fail_idx;
        r_first_fail_valid <= r_first_fail_valid;
      end
      if (r_idx == LAST_IDX) begin
        r_done <= 1'b1;
        r_pass <= (w_err_next == 4'd0);
        r_idx  <= r_idx;
        r_abc  <= r_abc;
      end else begin
        // The new vector is applied on the same edge that enters DRIVE.
        r_idx  <= r_idx + 3'd1;
        r_abc  <= r_idx + 3'd1;
        r_done <= r_done;
        r_pass <= r_pass;
      end
    end else begin
      r_idx              <= r_idx;
      r_abc              <= r_abc;
      r_done             <= r_done;
      r_pass             <= r_pass;
      r_err_count        <= r_err_count;
      r_first_fail_idx   <= r_first_fail_idx;
      r_first_fail_valid <= r_first_fail_valid;
    end
  end

`ifdef COMPUERTAS_BIST_FAIL_MASK_EN
  logic [7:0] r_fail_mask;

  // Per-vector mismatch flags, cleared on each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail_mask <= 8'd0;
    end else if (w_start_acc) begin
      r_fail_mask <= 8'd0;
    end else if (w_sample_exit && w_mismatch) begin
      r_fail_mask[r_idx] <= 1'b1;
    end else begin
      r_fail_mask <= r_fail_mask;
    end
  end

  assign fail_mask = r_fail_mask;
`endif

  assign a_out            = r_abc[2];
  assign b_out            = r_abc[1];
  assign c_out            = r_abc[0];
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err_count;
  assign first_fail_idx   = r_first_fail_idx;
  assign first_fail_valid = r_first_fail_valid;

endmodule : compuertas_bist

// File: tb/tb_compuertas_bist.sv
// -----------------------------------------------------------------------------
// tb_compuertas_bist
// Self-checking bench: two BIST instances (SETTLE_CYCLES=2 and 0), each beside
// a behavioural gate model (S1=A&B, S2=B|C) with an optional S1 stuck-at-0.
// Expected run results are computed from the gate model and pushed to a
// scoreboard queue at start; they are popped and compared when done rises.
// -----------------------------------------------------------------------------
module tb_compuertas_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst    = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic fault_s1 = 1'b0;
  logic sel = 1'b0;

  logic a0, b0, c0, busy0, done0, pass0, ffv0, s1_0, s2_0;
  logic [3:0] err0;
  logic [2:0] ffi0;
  logic a1, b1, c1, busy1, done1, pass1, ffv1, s1_1, s2_1;
  logic [3:0] err1;
  logic [2:0] ffi1;
`ifdef COMPUERTAS_BIST_FAIL_MASK_EN
  logic [7:0] mask0, mask1;
`endif

  // Gate block models.
  assign s1_0 = fault_s1 ? 1'b0 : (a0 & b0);
  assign s2_0 = b0 | c0;
  assign s1_1 = fault_s1 ? 1'b0 : (a1 & b1);
  assign s2_1 = b1 | c1;

  compuertas_bist #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .s1_in(s1_0), .s2_in(s2_0),
    .a_out(a0), .b_out(b0), .c_out(c0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .first_fail_idx(ffi0),
    .first_fail_valid(ffv0)
`ifdef COMPUERTAS_BIST_FAIL_MASK_EN
    , .fail_mask(mask0)
`endif
  );

  compuertas_bist #(.SETTLE_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .s1_in(s1_1), .s2_in(s2_1),
    .a_out(a1), .b_out(b1), .c_out(c1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .first_fail_idx(ffi1),
    .first_fail_valid(ffv1)
`ifdef COMPUERTAS_BIST_FAIL_MASK_EN
    , .fail_mask(mask1)
`endif
  );

  // Observation mux for the instance under test.
  logic [2:0] o_abc, o_ffi;
  logic [3:0] o_err;
  logic       o_busy, o_done, o_pass, o_ffv;
  logic [7:0] o_mask;
  assign o_abc  = sel ? {a1, b1, c1} : {a0, b0, c0};
  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_pass = sel ? pass1 : pass0;
  assign o_err  = sel ? err1  : err0;
  assign o_ffi  = sel ? ffi1  : ffi0;
  assign o_ffv  = sel ? ffv1  : ffv0;
`ifdef COMPUERTAS_BIST_FAIL_MASK_EN
  assign o_mask = sel ? mask1 : mask0;
`else
  assign o_mask = 8'd0;
`endif

  typedef struct {
    int unsigned err;
    bit          pass;
    int unsigned ffi;
    bit          ffv;
    logic [7:0]  mask;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  // Full run: p = cycles per vector; optional start re-pulse while busy.
  task automatic run_vectors(input int p, input bit repulse);
    exp_t e;
    bit   ga, gb, gc, s1, s2;
    e.err = 0; e.pass = 1'b0; e.ffi = 0; e.ffv = 1'b0; e.mask = 8'd0;
    for (int v = 0; v < 8; v++) begin
      ga = v[2]; gb = v[1]; gc = v[0];
      s1 = fault_s1 ? 1'b0 : (ga & gb);
      s2 = gb | gc;
      if ((s1 != (ga & gb)) || (s2 != (gb | gc))) begin
        e.err++;
        e.mask[v] = 1'b1;
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ffi = v;
        end
      end
    end
    e.pass = (e.err == 0);
    sb_q.push_back(e);

    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    for (int m = 0; m < 8 * p; m++) begin
      check_eq("abc", {29'd0, o_abc}, m / p);
      check_eq("busy", {31'd0, o_busy}, 1);
      check_eq("done_low", {31'd0, o_done}, 0);
      if (m == 0) begin
        check_eq("err_clr", {28'd0, o_err}, 0);
        check_eq("ffv_clr", {31'd0, o_ffv}, 0);
        check_eq("pass_clr", {31'd0, o_pass}, 0);
      end
      if (repulse && m == 9)  set_start(1'b1);
      if (repulse && m == 10) set_start(1'b0);
      @(negedge clk);
    end
    check_eq("done", {31'd0, o_done}, 1);
    check_eq("busy_end", {31'd0, o_busy}, 0);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check_eq("err_count", {28'd0, o_err}, e.err);
      check_eq("pass", {31'd0, o_pass}, {31'd0, e.pass});
      check_eq("ff_idx", {29'd0, o_ffi}, e.ffi);
      check_eq("ff_valid", {31'd0, o_ffv}, {31'd0, e.ffv});
`ifdef COMPUERTAS_BIST_FAIL_MASK_EN
      check_eq("fail_mask", {24'd0, o_mask}, {24'd0, e.mask});
`endif
    end
    // One idle cycle in DONE: done must hold.
    @(negedge clk);
    check_eq("done_hold", {31'd0, o_done}, 1);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_abc"}, {29'd0, o_abc}, 0);
    check_eq({tag, "_busy"}, {31'd0, o_busy}, 0);
    check_eq({tag, "_done"}, {31'd0, o_done}, 0);
    check_eq({tag, "_pass"}, {31'd0, o_pass}, 0);
    check_eq({tag, "_err"}, {28'd0, o_err}, 0);
    check_eq({tag, "_ffi"}, {29'd0, o_ffi}, 0);
    check_eq({tag, "_ffv"}, {31'd0, o_ffv}, 0);
`ifdef COMPUERTAS_BIST_FAIL_MASK_EN
    check_eq({tag, "_mask"}, {24'd0, o_mask}, 0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("rst0");
    sel = 1'b1; #1;
    check_reset("rst1");
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Clean run, default settle.
    fault_s1 = 1'b0; run_vectors(4, 1'b0);
    // S1 stuck-at-0, started from DONE.
    fault_s1 = 1'b1; run_vectors(4, 1'b0);
    // Correct DUT from DONE with err_count=2, plus start re-pulse while busy.
    fault_s1 = 1'b0; run_vectors(4, 1'b1);

    // Reset in the middle of SETTLE of vector 3.
    fault_s1 = 1'b1;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (13) @(negedge clk);
    check_eq("abc_pre_rst", {29'd0, o_abc}, 3);
    check_eq("busy_pre_rst", {31'd0, o_busy}, 1);
    #2 rst = 1'b1;
    #1 check_reset("mid_rst");
    @(negedge clk); rst = 1'b0;
    fault_s1 = 1'b0; run_vectors(4, 1'b0);

    // Zero settle cycles instance.
    sel = 1'b1;
    fault_s1 = 1'b0; run_vectors(2, 1'b0);
    fault_s1 = 1'b1; run_vectors(2, 1'b0);
    fault_s1 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_compuertas_bist
